// File: rtl/usb_ls_tx_pkg.sv
// usb_ls_tx_pkg: shared constants for the low-speed USB transmit serializer.
// It holds the FSM state encoding, the {dp,dm} line levels, the stuffing and
// EOP constants, and the NRZI step used by the serializer.
package usb_ls_tx_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SHIFT   = 2'd1;
   localparam logic [1:0] ST_EOP_SE0 = 2'd2;
   localparam logic [1:0] ST_EOP_J   = 2'd3;

   // Line levels as {dp,dm}. Low speed: J = D- high, K = D+ high.
   localparam logic [1:0] LINE_J   = 2'b01;
   localparam logic [1:0] LINE_K   = 2'b10;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   localparam logic [2:0] STUFF_THRESH = 3'd6;
   localparam logic [1:0] EOP_SE0_LEN  = 2'd2;
   localparam logic [3:0] BYTE_BITS    = 4'd8;

   // NRZI: a 0 toggles between J and K, a 1 holds the current level.
   function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic b);
      logic [1:0] nxt;
      nxt = line;
      if (!b) begin
         nxt = (line == LINE_J) ? LINE_K : LINE_J;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/usb_ls_tx_bitclk.sv
// usb_ls_bitclk: bit-time timer. A down-counter reloaded on packet start
// produces a one-cycle strobe in the last cycle of every bit time.
module usb_ls_bitclk #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic strobe
);

   localparam logic [3:0] RELOAD = 4'(CLK_DIV - 1);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Reload on clear or terminal count, otherwise count down.
   always_comb begin
      cnt_d = cnt_q - 4'd1;
      if (clr || (cnt_q == 4'd0)) begin
         cnt_d = RELOAD;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign strobe = (cnt_q == 4'd0);

endmodule

// File: rtl/usb_ls_tx.sv
// usb_ls_tx: low-speed USB transmit serializer. Serializes core bytes
// LSB-first with bit stuffing and NRZI, then appends SE0 SE0 J.
// Optional feature macro: USB_TX_PKTCNT_EN enables the completed-packet
// counter on tx_pkt_cnt; without it tx_pkt_cnt is tied to 0.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | line at J, oe low, waiting for start_pkt
// ST_SHIFT   | emitting data / stuff bits, one per bit time
// ST_EOP_SE0 | driving SE0 for EOP_SE0_LEN bit times
// ST_EOP_J   | driving J for one bit time before releasing the pads
module usb_ls_tx
   import usb_ls_tx_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_pkt,
   input  logic [7:0] sbyte,
   input  logic       last_pkt_byte,
   output logic       show_next,
   output logic       dp,
   output logic       dm,
   output logic       oe,
   output logic       busy,
   output logic [7:0] tx_pkt_cnt
);

   logic [1:0] state_q, state_d;
   logic [7:0] shreg_q, shreg_d;
   logic       last_q, last_d;
   logic [2:0] ones_q, ones_d;
   logic [3:0] bit_idx_q, bit_idx_d;
   logic [1:0] line_q, line_d;
   logic       oe_q, oe_d;
   logic       show_next_q, show_next_d;
   logic [1:0] eop_cnt_q, eop_cnt_d;

   logic       start_ok;
   logic       bit_stb;
   logic       load_byte;
   logic       data_bit;
   logic       stuff_bit;
   logic [7:0] src;
   logic [2:0] ones_base;

   assign start_ok = (state_q == ST_IDLE) && start_pkt;

   usb_ls_bitclk #(
      .CLK_DIV (CLK_DIV)
   ) u_bitclk (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (start_ok),
      .strobe (bit_stb)
   );

   // Sequencing: decide what the next bit time carries, then update the datapath.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      last_d      = last_q;
      ones_d      = ones_q;
      bit_idx_d   = bit_idx_q;
      line_d      = line_q;
      oe_d        = oe_q;
      show_next_d = 1'b0;
      eop_cnt_d   = eop_cnt_q;
      load_byte   = 1'b0;
      data_bit    = 1'b0;
      stuff_bit   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_pkt) begin
               load_byte = 1'b1;
               oe_d      = 1'b1;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (bit_stb) begin
               if (ones_q == STUFF_THRESH) begin
                  stuff_bit = 1'b1;
               end else if (bit_idx_q == BYTE_BITS) begin
                  if (last_q) begin
                     state_d   = ST_EOP_SE0;
                     line_d    = LINE_SE0;
                     eop_cnt_d = 2'd0;
                  end else begin
                     load_byte = 1'b1;
                  end
               end else begin
                  data_bit = 1'b1;
               end
            end
         end
         ST_EOP_SE0: begin
            if (bit_stb) begin
               if (eop_cnt_q == (EOP_SE0_LEN - 2'd1)) begin
                  state_d = ST_EOP_J;
                  line_d  = LINE_J;
               end else begin
                  eop_cnt_d = eop_cnt_q + 2'd1;
               end
            end
         end
         default: begin
            if (bit_stb) begin
               state_d = ST_IDLE;
               oe_d    = 1'b0;
            end
         end
      endcase

      // A fresh byte emits its bit 0 in the same step it is loaded, so the
      // core sees show_next while that bit is already on the line.
      src       = load_byte ? sbyte : shreg_q;
      ones_base = (state_q == ST_IDLE) ? 3'd0 : ones_q;

      if (stuff_bit) begin
         line_d = nrzi_next(line_q, 1'b0);
         ones_d = 3'd0;
      end

      if (load_byte || data_bit) begin
         line_d    = nrzi_next(line_q, src[0]);
         shreg_d   = {1'b0, src[7:1]};
         bit_idx_d = load_byte ? 4'd1 : (bit_idx_q + 4'd1);
         ones_d    = src[0] ? (ones_base + 3'd1) : 3'd0;
      end

      if (load_byte) begin
         last_d      = last_pkt_byte;
         show_next_d = 1'b1;
      end
   end

   // State and datapath registers; reset returns the pads to idle J.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         shreg_q     <= 8'd0;
         last_q      <= 1'b0;
         ones_q      <= 3'd0;
         bit_idx_q   <= 4'd0;
         line_q      <= LINE_J;
         oe_q        <= 1'b0;
         show_next_q <= 1'b0;
         eop_cnt_q   <= 2'd0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         last_q      <= last_d;
         ones_q      <= ones_d;
         bit_idx_q   <= bit_idx_d;
         line_q      <= line_d;
         oe_q        <= oe_d;
         show_next_q <= show_next_d;
         eop_cnt_q   <= eop_cnt_d;
      end
   end

   assign dp        = line_q[1];
   assign dm        = line_q[0];
   assign oe        = oe_q;
   assign busy      = (state_q != ST_IDLE);
   assign show_next = show_next_q;

`ifdef USB_TX_PKTCNT_EN
   logic [7:0] pkt_cnt_q, pkt_cnt_d;
   logic       pkt_done;

   assign pkt_done = (state_q == ST_EOP_J) && bit_stb;

   // Count packets whose final J bit time completed.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (pkt_done) begin
         pkt_cnt_d = pkt_cnt_q + 8'd1;
      end
   end

   // Packet counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_cnt_q <= 8'd0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign tx_pkt_cnt = pkt_cnt_q;
`else
   assign tx_pkt_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_usb_ls_tx.sv
// tb_usb_ls_tx: randomized packets against a bit-level reference model of
// stuffing, NRZI and EOP; every cycle of every packet is compared.
module tb_usb_ls_tx;

   localparam int DIV = 4;
   localparam logic [1:0] J = 2'b01;
   localparam logic [1:0] K = 2'b10;
   localparam logic [1:0] SE0 = 2'b00;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_pkt = 1'b0;
   logic [7:0] sbyte;
   logic       last_pkt_byte;
   logic       show_next, dp, dm, oe, busy;
   logic [7:0] tx_pkt_cnt;

   logic [7:0] pkt_mem [0:15];
   logic [7:0] desc [0:10] = '{8'h80, 8'h4B, 8'h12, 8'h01, 8'h10, 8'h01,
                               8'h00, 8'h00, 8'h00, 8'h08, 8'hC7};
   int n_bytes = 1;
   int ptr = 0;
   int n_vec = 0;
   int n_err = 0;
   int pkts_done = 0;
   int byte_start [0:15];
   logic [1:0] exp_sym [$];
   bit         exp_sn [$];

   usb_ls_tx #(.CLK_DIV(DIV)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_pkt     (start_pkt),
      .sbyte         (sbyte),
      .last_pkt_byte (last_pkt_byte),
      .show_next     (show_next),
      .dp            (dp),
      .dm            (dm),
      .oe            (oe),
      .busy          (busy),
      .tx_pkt_cnt    (tx_pkt_cnt)
   );

   always #5 clk = ~clk;

   // Function-core model: byte pointer advanced by show_next.
   assign sbyte = pkt_mem[ptr[3:0]];
   assign last_pkt_byte = (ptr == n_bytes - 1);
   always @(posedge clk) begin
      if (show_next) ptr <= ptr + 1;
      else if (!busy && !start_pkt) ptr <= 0;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_cnt();
`ifdef USB_TX_PKTCNT_EN
      return 8'(pkts_done);
`else
      return 8'd0;
`endif
   endfunction

   // Reference: per bit time line level, and whether show_next opens that bit time.
   task automatic build_model();
      logic [1:0] lvl;
      int ones;
      lvl = J;
      ones = 0;
      exp_sym.delete();
      exp_sn.delete();
      for (int b = 0; b < n_bytes; b++) begin
         byte_start[b] = exp_sym.size();
         for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = pkt_mem[b];
            if (!v[i]) lvl = (lvl == J) ? K : J;
            exp_sym.push_back(lvl);
            exp_sn.push_back(i == 0);
            ones = v[i] ? ones + 1 : 0;
            if (ones == 6) begin
               lvl = (lvl == J) ? K : J;
               exp_sym.push_back(lvl);
               exp_sn.push_back(1'b0);
               ones = 0;
            end
         end
      end
      exp_sym.push_back(SE0);
      exp_sym.push_back(SE0);
      exp_sym.push_back(J);
      repeat (3) exp_sn.push_back(1'b0);
   endtask

   task automatic run_packet(input int abort_k, input int collide_k);
      int total, sn_cnt, oe_cnt;
      logic [4:0] exp_v;
      logic       sn_exp;
      build_model();
      total = exp_sym.size() * DIV;
      @(negedge clk);
      start_pkt = 1'b1;
      @(negedge clk);
      start_pkt = 1'b0;
      sn_cnt = 0;
      oe_cnt = 0;
      for (int k = 0; k < total; k++) begin
         sn_exp = ((k % DIV) == 0) && exp_sn[k / DIV];
         exp_v = {1'b1, 1'b1, sn_exp, exp_sym[k / DIV]};
         check_val($sformatf("pkt%0d cyc%0d {oe,busy,sn,dp,dm}", pkts_done, k),
                   32'({oe, busy, show_next, dp, dm}), 32'(exp_v));
         if (show_next) sn_cnt++;
         if (oe) oe_cnt++;
         if (k == abort_k) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check_val("abort_idle", 32'({oe, busy, show_next, dp, dm}), 32'(5'b00001));
            check_val("abort_cnt", 32'(tx_pkt_cnt), 32'(exp_cnt()));
            return;
         end
         start_pkt = (k == collide_k);
         @(negedge clk);
      end
      start_pkt = 1'b0;
      check_val("end_idle", 32'({oe, busy, show_next, dp, dm}), 32'(5'b00001));
      check_val("sn_pulses", 32'(sn_cnt), 32'(n_bytes));
      check_val("oe_cycles", 32'(oe_cnt), 32'(total));
      pkts_done++;
      check_val("pkt_cnt", 32'(tx_pkt_cnt), 32'(exp_cnt()));
   endtask

   task automatic rand_pkt(input int n);
      n_bytes = n;
      pkt_mem[0] = 8'h80;
      for (int i = 1; i < n; i++)
         pkt_mem[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
   endtask

   initial begin
      int ak;
      for (int i = 0; i < 16; i++) pkt_mem[i] = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_lines", 32'({oe, busy, show_next, dp, dm}), 32'(5'b00001));
      check_val("rst_cnt", 32'(tx_pkt_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ACK handshake
      n_bytes = 2; pkt_mem[0] = 8'h80; pkt_mem[1] = 8'hD2;
      run_packet(-1, -1);
      // stuffing straddling SYNC into 0xFF
      n_bytes = 2; pkt_mem[0] = 8'h80; pkt_mem[1] = 8'hFF;
      run_packet(-1, -1);
      // descriptor-style packet, 11 bytes
      n_bytes = 11;
      for (int i = 0; i < 11; i++) pkt_mem[i] = desc[i];
      run_packet(-1, -1);
      // collision: second start during SHIFT
      n_bytes = 2; pkt_mem[0] = 8'h80; pkt_mem[1] = 8'hD2;
      run_packet(-1, 3 * DIV + 1);
      // abort during the third byte, then a normal packet
      rand_pkt(5);
      build_model();
      ak = byte_start[2] * DIV + int'($urandom_range(0, 7 * DIV));
      run_packet(ak, -1);
      @(negedge clk);
      rand_pkt(4);
      run_packet(-1, -1);

      // random packets, some with collisions
      for (int p = 0; p < 16; p++) begin
         rand_pkt(int'($urandom_range(1, 11)));
         if ($urandom_range(0, 1) == 1) run_packet(-1, int'($urandom_range(0, 8 * DIV)));
         else run_packet(-1, -1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
